// File: rtl/ram_arb_pkg.sv
// Shared defaults and helpers for the RAM port arbiter slice.
package ram_arb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 8;
    localparam int N_REQ_DEF  = 2;
    localparam int MAX_REQ    = 8;

    function automatic int ptr_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// N-way round-robin arbiter: combinational one-hot grant, pointer moves past the winner.
module rr_arbiter
    import ram_arb_pkg::*;
#(
    parameter int N_REQ = N_REQ_DEF,
    localparam int PTR_W = ptr_width(N_REQ)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] i_req,
    input  logic             i_advance,
    output logic [N_REQ-1:0] o_gnt
);

    logic [PTR_W-1:0] r_ptr;
    logic [PTR_W-1:0] w_gnt_idx;
    logic [PTR_W-1:0] w_pos;
    logic [PTR_W:0]   w_sum;
    logic [N_REQ-1:0] w_req;
    logic             w_found;

    // Requests are masked during reset so no grant can leak out.
    assign w_req = reset ? '0 : i_req;

    always_comb begin
        o_gnt     = '0;
        w_gnt_idx = '0;
        w_found   = 1'b0;
        w_sum     = '0;
        w_pos     = '0;
        for (int k = 0; k < N_REQ; k++) begin
            w_sum = {1'b0, r_ptr} + (PTR_W+1)'(k);
            if (w_sum >= (PTR_W+1)'(N_REQ)) begin
                w_sum = w_sum - (PTR_W+1)'(N_REQ);
            end
            w_pos = w_sum[PTR_W-1:0];
            if (!w_found && w_req[w_pos]) begin
                w_found      = 1'b1;
                w_gnt_idx    = w_pos;
                o_gnt[w_pos] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_ptr <= '0;
        end else if (i_advance && w_found) begin
            r_ptr <= (w_gnt_idx == PTR_W'(N_REQ - 1)) ? '0 : w_gnt_idx + PTR_W'(1);
        end
    end

endmodule

// File: rtl/ram_port_arbiter.sv
// Arbitrates N requesters onto one RAM write port and one RAM read port (read latency 1).
module ram_port_arbiter
    import ram_arb_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int N_REQ  = N_REQ_DEF
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [N_REQ-1:0]        i_wr_req,
    input  logic [N_REQ*ADDR_W-1:0] i_wr_addr,
    input  logic [N_REQ*DATA_W-1:0] i_wr_data,
    output logic [N_REQ-1:0]        o_wr_gnt,
    input  logic [N_REQ-1:0]        i_rd_req,
    input  logic [N_REQ*ADDR_W-1:0] i_rd_addr,
    output logic [N_REQ-1:0]        o_rd_gnt,
    output logic [N_REQ-1:0]        o_rd_valid,
    output logic [DATA_W-1:0]       o_rd_data,
    output logic                    o_ram_wr_enb,
    output logic [ADDR_W-1:0]       o_ram_wr_addr,
    output logic [DATA_W-1:0]       o_ram_data_in,
    output logic                    o_ram_rd_enb,
    output logic [ADDR_W-1:0]       o_ram_rd_addr,
    input  logic [DATA_W-1:0]       i_ram_data_out
);

    logic [N_REQ-1:0] w_wr_gnt;
    logic [N_REQ-1:0] w_rd_gnt;
    logic [N_REQ-1:0] r_rd_valid;

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_wr_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_wr_req),
        .i_advance (|w_wr_gnt),
        .o_gnt     (w_wr_gnt)
    );

    rr_arbiter #(
        .N_REQ(N_REQ)
    ) u_rd_arb (
        .clk       (clk),
        .reset     (reset),
        .i_req     (i_rd_req),
        .i_advance (|w_rd_gnt),
        .o_gnt     (w_rd_gnt)
    );

    assign o_wr_gnt     = w_wr_gnt;
    assign o_rd_gnt     = w_rd_gnt;
    assign o_ram_wr_enb = |w_wr_gnt;
    assign o_ram_rd_enb = |w_rd_gnt;

    // Grants are one-hot, so OR-ing the masked slices is a clean mux that idles at zero.
    always_comb begin
        o_ram_wr_addr = '0;
        o_ram_data_in = '0;
        o_ram_rd_addr = '0;
        for (int i = 0; i < N_REQ; i++) begin
            if (w_wr_gnt[i]) begin
                o_ram_wr_addr = o_ram_wr_addr | i_wr_addr[i*ADDR_W +: ADDR_W];
                o_ram_data_in = o_ram_data_in | i_wr_data[i*DATA_W +: DATA_W];
            end
            if (w_rd_gnt[i]) begin
                o_ram_rd_addr = o_ram_rd_addr | i_rd_addr[i*ADDR_W +: ADDR_W];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_rd_valid <= '0;
        end else begin
            r_rd_valid <= w_rd_gnt;
        end
    end

    // A read granted just before reset must not surface while reset is held.
    assign o_rd_valid = reset ? '0 : r_rd_valid;
    assign o_rd_data  = i_ram_data_out;

endmodule

// File: tb/tb_ram_port_arbiter.sv
// Directed checks on a 2-requester instance plus a randomized run on a 4-requester instance.
module tb_ram_port_arbiter;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Instance A: N_REQ = 2
    logic [1:0]  a_wr_req, a_wr_gnt, a_rd_req, a_rd_gnt, a_rd_valid;
    logic [15:0] a_wr_addr, a_wr_data, a_rd_addr;
    logic [7:0]  a_rd_data, a_ram_wr_addr, a_ram_data_in, a_ram_rd_addr, a_ram_dout;
    logic        a_ram_wr_enb, a_ram_rd_enb;
    logic [7:0]  mem_a [0:255] = '{default: 8'h00};

    // Instance B: N_REQ = 4
    logic [3:0]  b_wr_req, b_wr_gnt, b_rd_req, b_rd_gnt, b_rd_valid;
    logic [31:0] b_wr_addr, b_wr_data, b_rd_addr;
    logic [7:0]  b_rd_data, b_ram_wr_addr, b_ram_data_in, b_ram_rd_addr, b_ram_dout;
    logic        b_ram_wr_enb, b_ram_rd_enb;
    logic [7:0]  mem_b [0:255] = '{default: 8'h00};
    logic [7:0]  shadow [0:255] = '{default: 8'h00};

    ram_port_arbiter #(.DATA_W(8), .ADDR_W(8), .N_REQ(2)) u_dut_a (
        .clk(clk), .reset(reset),
        .i_wr_req(a_wr_req), .i_wr_addr(a_wr_addr), .i_wr_data(a_wr_data), .o_wr_gnt(a_wr_gnt),
        .i_rd_req(a_rd_req), .i_rd_addr(a_rd_addr), .o_rd_gnt(a_rd_gnt),
        .o_rd_valid(a_rd_valid), .o_rd_data(a_rd_data),
        .o_ram_wr_enb(a_ram_wr_enb), .o_ram_wr_addr(a_ram_wr_addr), .o_ram_data_in(a_ram_data_in),
        .o_ram_rd_enb(a_ram_rd_enb), .o_ram_rd_addr(a_ram_rd_addr), .i_ram_data_out(a_ram_dout)
    );

    ram_port_arbiter #(.DATA_W(8), .ADDR_W(8), .N_REQ(4)) u_dut_b (
        .clk(clk), .reset(reset),
        .i_wr_req(b_wr_req), .i_wr_addr(b_wr_addr), .i_wr_data(b_wr_data), .o_wr_gnt(b_wr_gnt),
        .i_rd_req(b_rd_req), .i_rd_addr(b_rd_addr), .o_rd_gnt(b_rd_gnt),
        .o_rd_valid(b_rd_valid), .o_rd_data(b_rd_data),
        .o_ram_wr_enb(b_ram_wr_enb), .o_ram_wr_addr(b_ram_wr_addr), .o_ram_data_in(b_ram_data_in),
        .o_ram_rd_enb(b_ram_rd_enb), .o_ram_rd_addr(b_ram_rd_addr), .i_ram_data_out(b_ram_dout)
    );

    // Parent-level RAMs with registered read data.
    always @(posedge clk) begin
        if (a_ram_wr_enb) mem_a[a_ram_wr_addr] <= a_ram_data_in;
        if (a_ram_rd_enb) a_ram_dout <= mem_a[a_ram_rd_addr];
        if (b_ram_wr_enb) mem_b[b_ram_wr_addr] <= b_ram_data_in;
        if (b_ram_rd_enb) b_ram_dout <= mem_b[b_ram_rd_addr];
    end

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset;
        reset = 1'b1;
        a_wr_req = '0;
        a_rd_req = '0;
        tick();
        reset = 1'b0;
    endtask

    function automatic int rr_pick(input logic [3:0] req, input int ptr);
        int idx;
        for (int k = 0; k < 4; k++) begin
            idx = (ptr + k) % 4;
            if (req[idx]) return idx;
        end
        return -1;
    endfunction

    task automatic test_reset;
        reset = 1'b1;
        a_wr_req = 2'b11; a_rd_req = 2'b11;
        a_wr_addr = {8'h02, 8'h01}; a_wr_data = 16'h0000; a_rd_addr = {8'h02, 8'h01};
        #1;
        n_checks += 5;
        if (a_wr_gnt !== 2'b00) begin n_errors++; $display("FAIL reset_wr_gnt: got %b expected 00", a_wr_gnt); end
        if (a_rd_gnt !== 2'b00) begin n_errors++; $display("FAIL reset_rd_gnt: got %b expected 00", a_rd_gnt); end
        if (a_ram_wr_enb !== 1'b0) begin n_errors++; $display("FAIL reset_wr_enb: got %b expected 0", a_ram_wr_enb); end
        if (a_ram_rd_enb !== 1'b0) begin n_errors++; $display("FAIL reset_rd_enb: got %b expected 0", a_ram_rd_enb); end
        if (a_rd_valid !== 2'b00) begin n_errors++; $display("FAIL reset_rd_valid: got %b expected 00", a_rd_valid); end
        tick();
        n_checks++;
        if (a_rd_valid !== 2'b00) begin n_errors++; $display("FAIL reset_rd_valid2: got %b expected 00", a_rd_valid); end
        reset = 1'b0;
        #1;
        n_checks += 3;
        if (a_wr_gnt !== 2'b01) begin n_errors++; $display("FAIL release_wr_gnt: got %b expected 01", a_wr_gnt); end
        if (a_rd_gnt !== 2'b01) begin n_errors++; $display("FAIL release_rd_gnt: got %b expected 01", a_rd_gnt); end
        if (a_ram_wr_addr !== 8'h01) begin n_errors++; $display("FAIL release_wr_addr: got %h expected 01", a_ram_wr_addr); end
        tick();
        a_wr_req = '0; a_rd_req = '0;
        n_checks++;
        if (a_rd_valid !== 2'b01) begin n_errors++; $display("FAIL release_rd_valid: got %b expected 01", a_rd_valid); end
    endtask

    task automatic test_alternate;
        logic [1:0] exp_gnt;
        logic [7:0] exp_addr, exp_data;
        do_reset();
        a_wr_addr = {8'h20, 8'h10}; a_wr_data = {8'h22, 8'h11}; a_wr_req = 2'b11;
        for (int c = 0; c < 6; c++) begin
            exp_gnt  = (c % 2 == 0) ? 2'b01 : 2'b10;
            exp_addr = (c % 2 == 0) ? 8'h10 : 8'h20;
            exp_data = (c % 2 == 0) ? 8'h11 : 8'h22;
            #1;
            n_checks += 3;
            if (a_wr_gnt !== exp_gnt) begin n_errors++; $display("FAIL alt_gnt c=%0d: got %b expected %b", c, a_wr_gnt, exp_gnt); end
            if (a_ram_wr_addr !== exp_addr) begin n_errors++; $display("FAIL alt_addr c=%0d: got %h expected %h", c, a_ram_wr_addr, exp_addr); end
            if (a_ram_data_in !== exp_data) begin n_errors++; $display("FAIL alt_data c=%0d: got %h expected %h", c, a_ram_data_in, exp_data); end
            tick();
        end
        a_wr_req = '0;
        #1;
        n_checks += 4;
        if (a_ram_wr_enb !== 1'b0) begin n_errors++; $display("FAIL idle_wr_enb: got %b expected 0", a_ram_wr_enb); end
        if (a_ram_wr_addr !== 8'h00) begin n_errors++; $display("FAIL idle_wr_addr: got %h expected 00", a_ram_wr_addr); end
        if (mem_a[8'h10] !== 8'h11) begin n_errors++; $display("FAIL alt_ram10: got %h expected 11", mem_a[8'h10]); end
        if (mem_a[8'h20] !== 8'h22) begin n_errors++; $display("FAIL alt_ram20: got %h expected 22", mem_a[8'h20]); end
    endtask

    task automatic test_write_read;
        do_reset();
        a_wr_addr = {8'h33, 8'h00}; a_wr_data = {8'hA5, 8'h00}; a_wr_req = 2'b10;
        #1;
        n_checks += 2;
        if (a_wr_gnt !== 2'b10) begin n_errors++; $display("FAIL wr33_gnt: got %b expected 10", a_wr_gnt); end
        if (a_ram_wr_addr !== 8'h33) begin n_errors++; $display("FAIL wr33_addr: got %h expected 33", a_ram_wr_addr); end
        tick();
        a_wr_req = '0;
        a_rd_addr = {8'h00, 8'h33}; a_rd_req = 2'b01;
        #1;
        n_checks += 2;
        if (a_rd_gnt !== 2'b01) begin n_errors++; $display("FAIL rd33_gnt: got %b expected 01", a_rd_gnt); end
        if (a_ram_rd_addr !== 8'h33) begin n_errors++; $display("FAIL rd33_addr: got %h expected 33", a_ram_rd_addr); end
        tick();
        a_rd_req = '0;
        n_checks += 2;
        if (a_rd_valid !== 2'b01) begin n_errors++; $display("FAIL rd33_valid: got %b expected 01", a_rd_valid); end
        if (a_rd_data !== 8'hA5) begin n_errors++; $display("FAIL rd33_data: got %h expected a5", a_rd_data); end
    endtask

    task automatic test_collision;
        do_reset();
        a_wr_addr = {8'h00, 8'h40}; a_wr_data = {8'h00, 8'h5A}; a_wr_req = 2'b01;
        a_rd_addr = {8'h40, 8'h00}; a_rd_req = 2'b10;
        #1;
        n_checks += 2;
        if (a_wr_gnt !== 2'b01) begin n_errors++; $display("FAIL col_wr_gnt: got %b expected 01", a_wr_gnt); end
        if (a_rd_gnt !== 2'b10) begin n_errors++; $display("FAIL col_rd_gnt: got %b expected 10", a_rd_gnt); end
        tick();
        a_wr_req = '0; a_rd_req = '0;
        n_checks += 2;
        if (a_rd_valid !== 2'b10) begin n_errors++; $display("FAIL col_valid: got %b expected 10", a_rd_valid); end
        if (a_rd_data !== 8'h00) begin n_errors++; $display("FAIL col_old_data: got %h expected 00", a_rd_data); end
        a_rd_req = 2'b10;
        tick();
        a_rd_req = '0;
        n_checks += 2;
        if (a_rd_valid !== 2'b10) begin n_errors++; $display("FAIL col_valid2: got %b expected 10", a_rd_valid); end
        if (a_rd_data !== 8'h5A) begin n_errors++; $display("FAIL col_new_data: got %h expected 5a", a_rd_data); end
    endtask

    task automatic test_back_to_back;
        logic [7:0] addrs [4] = '{8'h10, 8'h20, 8'h33, 8'h40};
        logic [7:0] datas [4] = '{8'h11, 8'h22, 8'hA5, 8'h5A};
        do_reset();
        a_rd_req = 2'b01;
        for (int k = 0; k < 4; k++) begin
            a_rd_addr = {8'h00, addrs[k]};
            #1;
            n_checks++;
            if (a_rd_gnt !== 2'b01) begin n_errors++; $display("FAIL b2b_gnt k=%0d: got %b expected 01", k, a_rd_gnt); end
            tick();
            n_checks += 2;
            if (a_rd_valid !== 2'b01) begin n_errors++; $display("FAIL b2b_valid k=%0d: got %b expected 01", k, a_rd_valid); end
            if (a_rd_data !== datas[k]) begin n_errors++; $display("FAIL b2b_data k=%0d: got %h expected %h", k, a_rd_data, datas[k]); end
        end
        a_rd_req = '0;
        tick();
        n_checks++;
        if (a_rd_valid !== 2'b00) begin n_errors++; $display("FAIL b2b_idle_valid: got %b expected 00", a_rd_valid); end
    endtask

    task automatic test_reset_kill;
        do_reset();
        a_wr_addr = {8'h00, 8'h10}; a_wr_data = {8'h00, 8'h11}; a_wr_req = 2'b01;
        a_rd_addr = {8'h00, 8'h33}; a_rd_req = 2'b01;
        #1;
        n_checks++;
        if (a_rd_gnt !== 2'b01) begin n_errors++; $display("FAIL kill_rd_gnt: got %b expected 01", a_rd_gnt); end
        tick();
        reset = 1'b1;
        a_wr_req = '0; a_rd_req = '0;
        #1;
        n_checks++;
        if (a_rd_valid !== 2'b00) begin n_errors++; $display("FAIL kill_valid: got %b expected 00", a_rd_valid); end
        tick();
        n_checks++;
        if (a_rd_valid !== 2'b00) begin n_errors++; $display("FAIL kill_valid2: got %b expected 00", a_rd_valid); end
        reset = 1'b0;
        a_wr_req = 2'b11; a_rd_req = 2'b11;
        #1;
        n_checks += 2;
        if (a_wr_gnt !== 2'b01) begin n_errors++; $display("FAIL kill_wr_ptr: got %b expected 01", a_wr_gnt); end
        if (a_rd_gnt !== 2'b01) begin n_errors++; $display("FAIL kill_rd_ptr: got %b expected 01", a_rd_gnt); end
        a_wr_req = '0; a_rd_req = '0;
        tick();
    endtask

    task automatic test_random;
        logic [3:0] exp_wg, exp_rg, prev_rg;
        logic [7:0] exp_waddr, exp_raddr, prev_data;
        int wp, rp, gw, gr;
        int wwait [4];
        int rwait [4];
        do_reset();
        b_wr_req = '0; b_rd_req = '0;
        wp = 0; rp = 0; prev_rg = '0; prev_data = '0;
        for (int i = 0; i < 4; i++) begin wwait[i] = 0; rwait[i] = 0; end
        for (int cyc = 0; cyc < 2000; cyc++) begin
            n_checks++;
            if (b_rd_valid !== prev_rg) begin n_errors++; $display("FAIL rand_valid cyc=%0d: got %b expected %b", cyc, b_rd_valid, prev_rg); end
            if (prev_rg != 4'b0000) begin
                n_checks++;
                if (b_rd_data !== prev_data) begin n_errors++; $display("FAIL rand_rd_data cyc=%0d: got %h expected %h", cyc, b_rd_data, prev_data); end
            end
            for (int i = 0; i < 4; i++) begin
                if (!b_wr_req[i] && $urandom_range(1, 0) == 1) begin
                    b_wr_req[i] = 1'b1;
                    b_wr_addr[i*8 +: 8] = 8'($urandom_range(7, 0));
                    b_wr_data[i*8 +: 8] = 8'($urandom_range(255, 0));
                end
                if (!b_rd_req[i] && $urandom_range(1, 0) == 1) begin
                    b_rd_req[i] = 1'b1;
                    b_rd_addr[i*8 +: 8] = 8'($urandom_range(7, 0));
                end
            end
            #1;
            gw = rr_pick(b_wr_req, wp);
            gr = rr_pick(b_rd_req, rp);
            exp_wg = '0; exp_rg = '0; exp_waddr = '0; exp_raddr = '0;
            if (gw >= 0) begin exp_wg[gw] = 1'b1; exp_waddr = b_wr_addr[gw*8 +: 8]; end
            if (gr >= 0) begin exp_rg[gr] = 1'b1; exp_raddr = b_rd_addr[gr*8 +: 8]; end
            n_checks += 4;
            if (b_wr_gnt !== exp_wg) begin n_errors++; $display("FAIL rand_wr_gnt cyc=%0d: got %b expected %b", cyc, b_wr_gnt, exp_wg); end
            if (b_rd_gnt !== exp_rg) begin n_errors++; $display("FAIL rand_rd_gnt cyc=%0d: got %b expected %b", cyc, b_rd_gnt, exp_rg); end
            if (b_ram_wr_addr !== exp_waddr) begin n_errors++; $display("FAIL rand_wr_addr cyc=%0d: got %h expected %h", cyc, b_ram_wr_addr, exp_waddr); end
            if (b_ram_rd_addr !== exp_raddr) begin n_errors++; $display("FAIL rand_rd_addr cyc=%0d: got %h expected %h", cyc, b_ram_rd_addr, exp_raddr); end
            if (gr >= 0) begin
                prev_data = shadow[exp_raddr];
                n_checks++;
                if (rwait[gr] >= 4) begin n_errors++; $display("FAIL rand_rd_starve cyc=%0d: got wait %0d expected below 4", cyc, rwait[gr]); end
                rp = (gr + 1) % 4;
            end
            if (gw >= 0) begin
                shadow[exp_waddr] = b_wr_data[gw*8 +: 8];
                n_checks++;
                if (wwait[gw] >= 4) begin n_errors++; $display("FAIL rand_wr_starve cyc=%0d: got wait %0d expected below 4", cyc, wwait[gw]); end
                wp = (gw + 1) % 4;
            end
            for (int i = 0; i < 4; i++) begin
                wwait[i] = (b_wr_req[i] && !exp_wg[i]) ? wwait[i] + 1 : 0;
                rwait[i] = (b_rd_req[i] && !exp_rg[i]) ? rwait[i] + 1 : 0;
            end
            prev_rg = exp_rg;
            tick();
            b_wr_req = b_wr_req & ~exp_wg;
            b_rd_req = b_rd_req & ~exp_rg;
        end
        b_wr_req = '0; b_rd_req = '0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1);
    end

    initial begin
        reset = 1'b1;
        a_wr_req = '0; a_rd_req = '0; a_wr_addr = '0; a_wr_data = '0; a_rd_addr = '0;
        b_wr_req = '0; b_rd_req = '0; b_wr_addr = '0; b_wr_data = '0; b_rd_addr = '0;
        repeat (2) tick();
        test_reset();
        test_alternate();
        test_write_read();
        test_collision();
        test_back_to_back();
        test_reset_kill();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
